lives_manager: RTL and testbench

- Sequential lives tracker for the memory game; owns the player's life count and game-over status.
- Sits directly upstream of the LED life-display decoder and drives its 4-bit lives input.
- Consumes single-cycle event pulses from the game controller: start, miss, level done.
- After each lost life, enforces a post-hit hold window so that one wrong press cannot cost several lives.

---
 rtl/lives_manager_pkg.sv | 25 ++
 rtl/lives_manager_hold_timer.sv | 47 ++++
 rtl/lives_manager.sv | 154 +++++++++++++++
 tb/tb_lives_manager.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lives_manager_pkg.sv
// lives_manager_pkg
//   Shared definitions for the lives tracker and the LED life-display decoder:
//   life-count width, default game parameters, FSM state type and a
//   saturating-increment helper.
package lives_manager_pkg;

  localparam int unsigned LIVES_W             = 4;
  localparam int unsigned DEF_MAX_LIVES       = 3;
  localparam int unsigned DEF_START_LIVES     = 3;
  localparam int unsigned DEF_HOLD_CYCLES     = 25000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  // Increment by one, never going past ceil.
  function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] v,
                                                 input logic [LIVES_W-1:0] ceil);
    return (v >= ceil) ? ceil : v + 1'b1;
  endfunction

endpackage

// File: rtl/lives_manager_hold_timer.sv
// hold_timer
//   Loadable down-counter timing the post-hit hold window.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_i   : asynchronous active-high reset (count -> 0)
//     load_i  : load HOLD_CYCLES-1 (highest priority)
//     clear_i : force count to 0
//     en_i    : count down by one per cycle, stopping at 0
//     done_o  : count is zero
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(HOLD_CYCLES - 1);
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lives_manager.sv
// lives_manager
//   Lives tracker for the memory game. Owns the life count and game-over
//   status, and enforces a hold window after each lost life so a single
//   wrong press cannot cost several lives.
//   Ports:
//     i_Clk        : clock, rising edge
//     i_Reset      : asynchronous active-high reset
//     i_Start      : pulse, start/restart game (highest priority)
//     i_Miss       : pulse, player error
//     i_Level_Done : pulse, level cleared (bonus life when enabled)
//     o_Lives      : registered life count to the LED decoder
//     o_Game_Over  : high while in OVER
//     o_Life_Lost  : one-cycle pulse per decrement
//     o_Hold       : high during the hold window
//   Build option: define LIVES_BONUS_LIFE_EN to award a life (saturating at
//   MAX_LIVES) on i_Level_Done in PLAY or HOLD. Otherwise i_Level_Done is
//   ignored.
module lives_manager
  import lives_manager_pkg::*;
#(
  parameter int unsigned MAX_LIVES   = DEF_MAX_LIVES,
  parameter int unsigned START_LIVES = DEF_START_LIVES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Start,
  input  logic               i_Miss,
  input  logic               i_Level_Done,
  output logic [LIVES_W-1:0] o_Lives,
  output logic               o_Game_Over,
  output logic               o_Life_Lost,
  output logic               o_Hold
);

  if ((MAX_LIVES < 1) || (MAX_LIVES > 15)) begin : g_bad_max
    $error("lives_manager: MAX_LIVES must be in 1..15");
  end
  if (START_LIVES > MAX_LIVES) begin : g_bad_start
    $error("lives_manager: START_LIVES must not exceed MAX_LIVES");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("lives_manager: HOLD_CYCLES must be at least 1");
  end

  localparam logic [LIVES_W-1:0] MAX_L   = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] START_L = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] ONE_L   = LIVES_W'(1);

  state_t             state_q;
  logic [LIVES_W-1:0] lives_q;
  logic               over_q;
  logic               lost_q;
  logic               hold_q;

  logic tmr_load;
  logic tmr_clear;
  logic tmr_en;
  logic tmr_done;
  logic bonus_evt;

`ifdef LIVES_BONUS_LIFE_EN
  assign bonus_evt = i_Level_Done;
`else
  logic unused_level_done;
  assign unused_level_done = i_Level_Done;
  assign bonus_evt         = 1'b0;
`endif

  // Timer control mirrors the FSM decisions below: load on a miss that
  // leaves lives remaining, clear on any start.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_clear = i_Start;
    tmr_en    = 1'b0;
    if (!i_Start) begin
      tmr_load = (state_q == ST_PLAY) && i_Miss && (lives_q != ONE_L);
      tmr_en   = (state_q == ST_HOLD);
    end
  end

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk_i  (i_Clk),
    .rst_i  (i_Reset),
    .load_i (tmr_load),
    .clear_i(tmr_clear),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      lives_q <= '0;
      over_q  <= 1'b0;
      lost_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      if (i_Start) begin
        state_q <= ST_PLAY;
        lives_q <= START_L;
        over_q  <= 1'b0;
        hold_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            lives_q <= '0;
          end
          ST_PLAY: begin
            // A miss wins over a simultaneous level-done event.
            if (i_Miss) begin
              lives_q <= lives_q - 1'b1;
              lost_q  <= 1'b1;
              if (lives_q == ONE_L) begin
                state_q <= ST_OVER;
                over_q  <= 1'b1;
              end else begin
                state_q <= ST_HOLD;
                hold_q  <= 1'b1;
              end
            end else if (bonus_evt) begin
              lives_q <= sat_inc(lives_q, MAX_L);
            end
          end
          ST_HOLD: begin
            if (tmr_done) begin
              state_q <= ST_PLAY;
              hold_q  <= 1'b0;
            end
            if (bonus_evt) begin
              lives_q <= sat_inc(lives_q, MAX_L);
            end
          end
          ST_OVER: begin
            lives_q <= '0;
            over_q  <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_Lives     = lives_q;
  assign o_Game_Over = over_q;
  assign o_Life_Lost = lost_q;
  assign o_Hold      = hold_q;

endmodule

// File: tb/tb_lives_manager.sv
module tb_lives_manager;

`ifdef LIVES_BONUS_LIFE_EN
  localparam int BONUS = 1;
`else
  localparam int BONUS = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       miss;
  logic       level;
  logic [3:0] lives;
  logic       over;
  logic       lost;
  logic       hold;

  int errors = 0;
  int checks = 0;

  lives_manager #(
    .MAX_LIVES  (3),
    .START_LIVES(3),
    .HOLD_CYCLES(4)
  ) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Start     (start),
    .i_Miss      (miss),
    .i_Level_Done(level),
    .o_Lives     (lives),
    .o_Game_Over (over),
    .o_Life_Lost (lost),
    .o_Hold      (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       mi;
    logic       lv;
    logic [3:0] lives;
    logic       over;
    logic       lost;
    logic       hold;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl[NVEC];

  task automatic check(input string name, input logic [3:0] e_lives, input logic e_over,
                       input logic e_lost, input logic e_hold);
    checks++;
    if (lives !== e_lives || over !== e_over || lost !== e_lost || hold !== e_hold) begin
      errors++;
      $display("FAIL %s: got lives=%0d over=%b lost=%b hold=%b, want lives=%0d over=%b lost=%b hold=%b",
               name, lives, over, lost, hold, e_lives, e_over, e_lost, e_hold);
    end
  endtask

  // One clock: inputs set on the falling edge, outputs sampled 1 after rising edge.
  task automatic step(input logic s, input logic m, input logic l);
    @(negedge clk);
    start = s;
    miss  = m;
    level = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    miss  = 1'b0;
    level = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_l;

    //            st mi lv lives over lost hold
    tbl[0]  = '{0, 0, 0, 4'd0, 0, 0, 0};  // idle
    tbl[1]  = '{0, 1, 0, 4'd0, 0, 0, 0};  // miss ignored in idle
    tbl[2]  = '{1, 0, 0, 4'd3, 0, 0, 0};  // start
    tbl[3]  = '{0, 0, 0, 4'd3, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 4'd2, 0, 1, 1};  // first miss, hold cycle 1
    tbl[5]  = '{0, 1, 0, 4'd2, 0, 0, 1};  // miss in hold ignored (2)
    tbl[6]  = '{0, 0, 0, 4'd2, 0, 0, 1};  // (3)
    tbl[7]  = '{0, 1, 0, 4'd2, 0, 0, 1};  // (4)
    tbl[8]  = '{0, 0, 0, 4'd2, 0, 0, 0};  // back in play
    tbl[9]  = '{0, 1, 1, 4'd1, 0, 1, 1};  // miss beats level done
    tbl[10] = '{0, 0, 0, 4'd1, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 4'd1, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 4'd1, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 4'd1, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 4'd0, 1, 1, 0};  // last life, no hold
    tbl[15] = '{0, 0, 0, 4'd0, 1, 0, 0};
    tbl[16] = '{0, 1, 0, 4'd0, 1, 0, 0};  // miss in over ignored
    tbl[17] = '{0, 0, 1, 4'd0, 1, 0, 0};  // level in over ignored
    tbl[18] = '{1, 0, 0, 4'd3, 0, 0, 0};  // restart from over
    tbl[19] = '{0, 0, 1, 4'd3, 0, 0, 0};  // level at max: saturated or ignored
    tbl[20] = '{1, 1, 0, 4'd3, 0, 0, 0};  // start beats miss
    tbl[21] = '{0, 1, 0, 4'd2, 0, 1, 1};
    tbl[22] = '{1, 0, 0, 4'd3, 0, 0, 0};  // start aborts hold
    tbl[23] = '{0, 0, 0, 4'd3, 0, 0, 0};
    tbl[24] = '{0, 1, 0, 4'd2, 0, 1, 1};
    tbl[25] = '{1, 1, 0, 4'd3, 0, 0, 0};  // start+miss inside hold
    tbl[26] = '{0, 0, 0, 4'd3, 0, 0, 0};

    rst   = 1'b1;
    start = 1'b0;
    miss  = 1'b0;
    level = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].st, tbl[i].mi, tbl[i].lv);
      check($sformatf("vec%0d", i), tbl[i].lives, tbl[i].over, tbl[i].lost, tbl[i].hold);
    end

    // Level done during hold: bonus (if built in) must not disturb window length.
    step(0, 1, 0);
    check("bonus_miss", 4'd2, 0, 1, 1);
    exp_l = 4'(2 + BONUS);
    step(0, 0, 1);
    check("level_in_hold", exp_l, 0, 0, 1);
    step(0, 0, 0);
    check("hold_c3", exp_l, 0, 0, 1);
    step(0, 0, 0);
    check("hold_c4", exp_l, 0, 0, 1);
    step(0, 0, 0);
    check("hold_end", exp_l, 0, 0, 0);
    exp_l = (BONUS != 0) ? 4'd3 : 4'd2;
    step(0, 0, 1);
    check("level_in_play", exp_l, 0, 0, 0);
    step(0, 1, 1);
    check("miss_level_together", exp_l - 4'd1, 0, 1, 1);

    // Asynchronous reset in the middle of a hold window.
    step(1, 0, 0);
    check("restart", 4'd3, 0, 0, 0);
    step(0, 1, 0);
    check("pre_reset_hold", 4'd2, 0, 1, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_now", 4'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("reset_held", 4'd0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0);
    check("idle_after_reset", 4'd0, 0, 0, 0);
    step(1, 0, 0);
    check("start_after_reset", 4'd3, 0, 0, 0);
    step(0, 0, 0);
    check("play_after_reset", 4'd3, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
